// File: rtl/clk_gen_pkg.sv
// Shared definitions for the oscillator-driven clock divider: FSM state encoding
// and the default divide-value width.
package clk_gen_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/clk_gen_ds_cfg_slot.sv
// Single-entry valid/ready holding register for a new divide value.
// The divider FSM empties it with load_i when the value is taken into use.
module clk_gen_ds_cfg_slot #(
    parameter int WIDTH_P = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               cfg_v_i,
    input  logic [WIDTH_P-1:0] cfg_val_i,
    input  logic               load_i,
    output logic               cfg_ready_o,
    output logic               pending_o,
    output logic [WIDTH_P-1:0] pending_val_o
);

    logic               full_reg;
    logic [WIDTH_P-1:0] data_reg;

    // A full slot refuses new writes; load_i only ever arrives while full.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (cfg_v_i && !full_reg) begin
            full_reg <= 1'b1;
            data_reg <= cfg_val_i;
        end else if (load_i) begin
            full_reg <= 1'b0;
        end
    end

    assign cfg_ready_o   = ~full_reg;
    assign pending_o     = full_reg;
    assign pending_val_o = data_reg;

endmodule

// File: rtl/clk_gen_downsampler.sv
// Glitch-free programmable divider: clk_o period = 2*(cfg_val_o+1) clk_i cycles.
// Define CLK_GEN_DS_STATS_EN to add the periods_o counter of completed clk_o periods.
module clk_gen_downsampler
    import clk_gen_pkg::*;
#(
    parameter int                 WIDTH_P     = WIDTH_DEFAULT,
    parameter logic [WIDTH_P-1:0] RESET_VAL_P = '0
`ifdef CLK_GEN_DS_STATS_EN
   ,parameter int                 STATS_WIDTH_P = 16
`endif
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic               cfg_v_i,
    input  logic [WIDTH_P-1:0] cfg_val_i,
    output logic               cfg_ready_o,
    output logic [WIDTH_P-1:0] cfg_val_o,
    output logic               clk_o
`ifdef CLK_GEN_DS_STATS_EN
   ,output logic [STATS_WIDTH_P-1:0] periods_o
`endif
);

    state_t             state_reg, state_next;
    logic [WIDTH_P-1:0] ctr_reg, ctr_next;
    logic [WIDTH_P-1:0] val_reg, val_next;
    logic               clk_reg, clk_next;
    logic               fall;
    logic               load;
    logic               pending;
    logic [WIDTH_P-1:0] pending_val;
    logic               match;

    clk_gen_ds_cfg_slot #(.WIDTH_P(WIDTH_P)) u_slot (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .cfg_v_i       (cfg_v_i),
        .cfg_val_i     (cfg_val_i),
        .load_i        (load),
        .cfg_ready_o   (cfg_ready_o),
        .pending_o     (pending),
        .pending_val_o (pending_val)
    );

    assign match = (ctr_reg == val_reg);

    always_comb begin
        state_next = state_reg;
        ctr_next   = ctr_reg;
        clk_next   = clk_reg;
        fall       = 1'b0;
        case (state_reg)
            ST_STOP: begin
                ctr_next = '0;
                clk_next = 1'b0;
                if (en_i) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!en_i && !clk_reg) begin
                    // Stopping in the low phase: never start a truncated high pulse.
                    state_next = ST_STOP;
                    ctr_next   = '0;
                end else if (match) begin
                    clk_next = ~clk_reg;
                    ctr_next = '0;
                    if (clk_reg) begin
                        fall = 1'b1;
                        if (!en_i) state_next = ST_STOP;
                    end
                end else begin
                    ctr_next = ctr_reg + 1'b1;
                    if (!en_i) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (match) begin
                    clk_next   = 1'b0;
                    ctr_next   = '0;
                    fall       = 1'b1;
                    state_next = en_i ? ST_RUN : ST_STOP;
                end else begin
                    ctr_next = ctr_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_STOP;
                ctr_next   = '0;
                clk_next   = 1'b0;
            end
        endcase
    end

    // New values only take over at the start of a low phase, so periods never mix values.
    assign load     = pending && (fall || (state_reg == ST_STOP));
    assign val_next = load ? pending_val : val_reg;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= ST_STOP;
            ctr_reg   <= '0;
            val_reg   <= RESET_VAL_P;
            clk_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ctr_reg   <= ctr_next;
            val_reg   <= val_next;
            clk_reg   <= clk_next;
        end
    end

    assign clk_o     = clk_reg;
    assign cfg_val_o = val_reg;

`ifdef CLK_GEN_DS_STATS_EN
    logic [STATS_WIDTH_P-1:0] periods_reg;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            periods_reg <= '0;
        end else if (fall) begin
            periods_reg <= periods_reg + 1'b1;
        end
    end

    assign periods_o = periods_reg;
`endif

endmodule
